// File: rtl/cpu_run_monitor.sv
// Run-control and signature monitor for the single-cycle MIPS core: tracks run
// cycles, register writes, halt/timeout completion. Define CPU_RUN_MONITOR_MEMSIG_EN
// to also fold data-memory writes into the signature.
module cpu_run_monitor #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          RA_W        = 5,
  parameter int unsigned          CNT_W       = 32,
  parameter int unsigned          HALT_REPEAT = 4,
  parameter int unsigned          MAX_CYCLES  = 1000,
  parameter logic [DATA_W-1:0]    SIG_SEED    = '0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] pc,
  input  logic              RegWrite,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] WD3,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] WriteDataMem,
  input  logic [DATA_W-1:0] expect_sig,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  writes,
  output logic [DATA_W-1:0] sig,
  output logic              done,
  output logic              pass
);

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_HALT    = 2'b10;
  localparam logic [1:0] S_TIMEOUT = 2'b11;

  localparam int unsigned ST_W = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cycles_q,   cycles_d;
  logic [CNT_W-1:0]  writes_q,   writes_d;
  logic [DATA_W-1:0] sig_q,      sig_d;
  logic [DATA_W-1:0] pc_q,       pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic [ST_W-1:0]   stable_q,   stable_d;

  logic match, halt, tmo;

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] s);
    return {s[DATA_W-2:0], s[DATA_W-1]};
  endfunction

`ifndef CPU_RUN_MONITOR_MEMSIG_EN
  logic unused_mem;
  assign unused_mem = ^{MemWrite, ALUresult, WriteDataMem};
`endif

  assign match = pc_valid_q && (pc == pc_q);
  assign halt  = match && (stable_q == ST_W'(HALT_REPEAT - 1));
  assign tmo   = (cycles_q == CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    writes_d   = writes_q;
    sig_d      = sig_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    stable_d   = stable_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        cycles_d   = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
        pc_d       = pc;
        pc_valid_d = 1'b1;
        stable_d   = match ? stable_q + 1'b1 : '0;
        if (RegWrite && (wa != '0)) begin
          writes_d = (writes_q == '1) ? writes_q : writes_q + 1'b1;
          sig_d    = rotl1(sig_q) ^ WD3 ^ DATA_W'(wa);
        end
`ifdef CPU_RUN_MONITOR_MEMSIG_EN
        // memory term folds on top of any same-edge register term
        if (MemWrite) sig_d = rotl1(sig_d) ^ WriteDataMem ^ ALUresult;
`endif
        if (halt)     state_d = S_HALT;
        else if (tmo) state_d = S_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cycles_q   <= '0;
      writes_q   <= '0;
      sig_q      <= SIG_SEED;
      pc_q       <= '0;
      pc_valid_q <= 1'b0;
      stable_q   <= '0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      writes_q   <= writes_d;
      sig_q      <= sig_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      stable_q   <= stable_d;
    end
  end

  assign state  = state_q;
  assign cycles = cycles_q;
  assign writes = writes_q;
  assign sig    = sig_q;
  assign done   = (state_q == S_HALT) || (state_q == S_TIMEOUT);
  assign pass   = (state_q == S_HALT) && (sig_q == expect_sig);

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: a history-based reference model pushes
// expected outputs per edge; a negedge monitor pops and compares.
module tb_cpu_run_monitor;

  localparam int HR  = 4;
  localparam int MAX = 16;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, RegWrite = 1'b0, MemWrite = 1'b0;
  logic [31:0] pc = '0, WD3 = '0, ALUresult = '0, WriteDataMem = '0, expect_sig = '0;
  logic [4:0]  wa = '0;
  logic [1:0]  state;
  logic [31:0] cycles, writes, sig;
  logic        done, pass;

  logic        en2 = 1'b0;
  logic [31:0] pc2 = '0;
  logic [1:0]  state2;
  logic [31:0] cycles2, writes2, sig2;
  logic        done2, pass2;

  always #5 CLK = ~CLK;

  cpu_run_monitor #(.DATA_W(32), .RA_W(5), .CNT_W(32), .HALT_REPEAT(HR),
                    .MAX_CYCLES(MAX), .SIG_SEED(32'h0)) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .pc(pc), .RegWrite(RegWrite),
    .wa(wa), .WD3(WD3), .MemWrite(MemWrite), .ALUresult(ALUresult),
    .WriteDataMem(WriteDataMem), .expect_sig(expect_sig), .state(state),
    .cycles(cycles), .writes(writes), .sig(sig), .done(done), .pass(pass));

  cpu_run_monitor #(.DATA_W(32), .RA_W(5), .CNT_W(32), .HALT_REPEAT(4),
                    .MAX_CYCLES(6), .SIG_SEED(32'h0)) dut2 (
    .CLK(CLK), .reset(reset), .enable(en2), .pc(pc2), .RegWrite(1'b0),
    .wa(5'd0), .WD3(32'h0), .MemWrite(1'b0), .ALUresult(32'h0),
    .WriteDataMem(32'h0), .expect_sig(32'h0), .state(state2),
    .cycles(cycles2), .writes(writes2), .sig(sig2), .done(done2), .pass(pass2));

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          tag;
    logic [1:0]  st;
    logic [31:0] cy, wr, sg;
    logic        dn, ps;
  } exp_t;
  exp_t q[$];

  // Reference model: run state as a phase number plus the history of RUN pcs
  int          m_phase;  // 0 idle, 1 run, 2 halt, 3 timeout
  longint      m_cycles, m_writes;
  logic [31:0] m_sig;
  logic [31:0] run_pcs[$];

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] a, input logic [31:0] b);
    return {s[30:0], s[31]} ^ a ^ b;
  endfunction

  function automatic bit last_pcs_equal();
    int n = run_pcs.size();
    if (n < HR + 1) return 0;
    for (int i = 1; i <= HR; i++)
      if (run_pcs[n-1-i] != run_pcs[n-1]) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cycles = 0; m_writes = 0; m_sig = '0;
    run_pcs.delete();
  endtask

  // Called at posedge+1: drive inputs for the next edge, predict, push, advance.
  task automatic step(input logic en, input logic [31:0] p, input logic rw, input logic [4:0] a,
                      input logic [31:0] d, input logic mw, input logic [31:0] al, input logic [31:0] wm);
    exp_t e;
    enable = en; pc = p; RegWrite = rw; wa = a; WD3 = d;
    MemWrite = mw; ALUresult = al; WriteDataMem = wm;
    if (m_phase == 0) begin
      if (en) m_phase = 1;
    end else if (m_phase == 1) begin
      m_cycles++;
      if (rw && a != 0) begin
        m_writes++;
        m_sig = fold(m_sig, d, {27'd0, a});
      end
`ifdef CPU_RUN_MONITOR_MEMSIG_EN
      if (mw) m_sig = fold(m_sig, wm, al);
`endif
      run_pcs.push_back(p);
      if (last_pcs_equal())     m_phase = 2;
      else if (m_cycles == MAX) m_phase = 3;
    end
    e.tag = cyc + 1;
    e.st  = 2'(m_phase);
    e.cy  = 32'(m_cycles);
    e.wr  = 32'(m_writes);
    e.sg  = m_sig;
    e.dn  = (m_phase >= 2);
    e.ps  = (m_phase == 2) && (m_sig == expect_sig);
    q.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic idle_step(); step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0); endtask
  task automatic pc_step(input logic [31:0] p); step(1'b0, p, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0); endtask
  task automatic go(); step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0); endtask

  // Called at posedge+1: reset asynchronously after the pending check, verify immediately.
  task automatic do_reset();
    #5;
    reset = 1'b1;
    model_reset();
    q.delete();
    #1;
    check("rst_state", 32'(state), 32'h0);
    check("rst_cycles", cycles, 32'h0);
    check("rst_writes", writes, 32'h0);
    check("rst_sig", sig, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("cycles", cycles, e.cy);
      check("writes", writes, e.wr);
      check("sig", sig, e.sg);
      check("done", 32'(done), 32'(e.dn));
      check("pass", 32'(pass), 32'(e.ps));
    end
  end

  initial begin
    model_reset();
    #22 reset = 1'b0;
    @(posedge CLK); #1;
    repeat (5) idle_step();
    check("idle_state", 32'(state), 32'h0);

    // counted writes and a write to register 0
    go();
    step(1'b0, 32'h0, 1'b1, 5'd5, 32'h10, 1'b0, 32'h0, 32'h0);
    check("w1_sig", sig, 32'h00000015);
    step(1'b0, 32'h4, 1'b1, 5'd8, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h8, 1'b1, 5'd0, 32'h1234, 1'b0, 32'h0, 32'h0);
    check("w3_sig", sig, 32'hFFFFFFDD);
    check("w3_writes", writes, 32'd2);

    // halt after pc settles at 0x20
    do_reset();
    expect_sig = 32'h0;
    go();
    pc_step(32'h0); pc_step(32'h4); pc_step(32'h8);
    repeat (5) pc_step(32'h20);
    check("halt_state", 32'(state), 32'h2);
    check("halt_cycles", cycles, 32'd8);
    check("halt_pass", 32'(pass), 32'h1);
    repeat (3) pc_step(32'h24);

    // timeout with steadily advancing pc
    do_reset();
    go();
    for (int i = 0; i < 20; i++) pc_step(32'(4 * i));
    check("tmo_state", 32'(state), 32'h3);
    check("tmo_cycles", cycles, 32'd16);
    check("tmo_pass", 32'(pass), 32'h0);

    // memory write folding
    do_reset();
    go();
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'h1);
`ifdef CPU_RUN_MONITOR_MEMSIG_EN
    check("mem_sig", sig, 32'h00000101);
`else
    check("mem_sig", sig, 32'h0);
`endif
    check("mem_writes", writes, 32'h0);

    // randomized runs; each next reset typically lands mid-run
    for (int r = 0; r < 12; r++) begin
      logic [31:0] p;
      do_reset();
      expect_sig = (r % 3 == 0) ? 32'h0 : $urandom;
      repeat ($urandom_range(0, 3))
        step(1'b0, $urandom, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom);
      go();
      p = 32'h0;
      repeat ($urandom_range(4, 24)) begin
        logic rw;
        if ($urandom_range(0, 1) == 0) p = 32'(4 * $urandom_range(0, 3));
        rw = (r % 3 == 0) ? 1'b0 : 1'($urandom);
        step(1'($urandom), p, rw, 5'($urandom_range(0, 3)), $urandom,
             1'($urandom), $urandom, $urandom);
      end
    end

    // second instance: halt and timeout coincide on edge 6
    do_reset();
    en2 = 1'b1; @(posedge CLK); #1; en2 = 1'b0;
    pc2 = 32'h40; @(posedge CLK); #1;
    pc2 = 32'h44;
    begin
      int n = 0;
      while (!done2 && n < 20) begin @(posedge CLK); #1; n++; end
      if (!done2) begin errors++; checks++; $display("FAIL sim_wait: done2 never rose"); end
    end
    check("sim_state", 32'(state2), 32'h2);
    check("sim_cycles", cycles2, 32'd6);

    // second instance: minimum halt latency with pc constant from the first RUN cycle
    do_reset();
    en2 = 1'b1; pc2 = 32'h80; @(posedge CLK); #1; en2 = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    check("min_state", 32'(state2), 32'h2);
    check("min_cycles", cycles2, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
